// File: rtl/seq_bus_ctl_pkg.sv
// Shared definitions for the bus-cycle sequencer family.
package seq_pkg;

  // T-state encoding; the numeric value is what appears on the tstate output.
  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } tstate_e;

  // Default stretch limit and the wait-counter width that can hold it.
  localparam int WAIT_MAX_DEF = 15;
  localparam int WCNT_W_DEF   = 4;

  // Access record as it travels from request to acknowledge.
  typedef struct packed {
    logic       we;
    logic [7:0] data;
  } acc_t;

endpackage

// File: rtl/seq_bus_ctl_if.sv
// Bus between the instruction sequencer / memory pins and the bus-cycle
// sequencer. "slave" is the controller's view, "master" the environment's.
interface seq_bus_ctl_if;
  // request side
  logic       req;
  logic       we;
  logic [7:0] wdata;
  logic       hold;
  // memory side
  logic       nwait;
  logic [7:0] din;
  logic       nmreq;
  logic       nrd;
  logic       nwr;
  logic       addr_le;
  logic       dout_oe;
  logic [7:0] dout;
  // status
  logic [7:0] rdata;
  logic       ack;
  logic [1:0] tstate;
  logic       m_end;
  logic       parked;
  logic       timeout;

  modport slave (
    input  req, we, wdata, hold, nwait, din,
    output nmreq, nrd, nwr, addr_le, dout_oe, dout,
           rdata, ack, tstate, m_end, parked, timeout
  );

  modport master (
    output req, we, wdata, hold, nwait, din,
    input  nmreq, nrd, nwr, addr_le, dout_oe, dout,
           rdata, ack, tstate, m_end, parked, timeout
  );
endinterface

// File: rtl/seq_bus_ctl_tcnt.sv
// Two-bit T-state counter: T1->T2->T3->T4->T1, holds on stall, pinned to
// T1 while parked. Also used by the interrupt sequencer.
module seq_tcnt
  import seq_pkg::*;
(
  input  logic    clk,
  input  logic    nres,
  input  logic    stall,
  input  logic    park,
  output tstate_e tstate
);

  // T-state register; park dominates stall so a parked machine sits in T1.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres)       tstate <= T1;
    else if (park)   tstate <= T1;
    else if (!stall) tstate <= tstate_e'(tstate + 2'd1);
  end

endmodule

// File: rtl/seq_bus_ctl.sv
// Bus-cycle sequencer: frames M-cycles into T1..T4, runs one read or write
// per M-cycle, stretches T2 on nwait and parks on hold. All strobes are
// decoded from registered state only.
module seq_bus_ctl
  import seq_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int WCNT_W   = WCNT_W_DEF     // 2**WCNT_W must exceed WAIT_MAX
)(
  input  logic          clk,
  input  logic          nres,
  seq_bus_ctl_if.slave  bus
);

  localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(WAIT_MAX);

  tstate_e           tstate;
  logic              access;    // current M-cycle carries an access
  logic              we_r;      // access direction latched with req
  logic              parked;
  logic              timeout_r;
  logic [WCNT_W-1:0] wcnt;
  logic [7:0]        dout_r;
  logic [7:0]        rdata_r;

  logic leave_t4;   // edge that ends a running M-cycle
  logic wait_req;   // memory asks for a stretch this clk
  logic at_lim;     // stretch budget exhausted
  logic stall;      // hold the counter in T2

  assign leave_t4 = (tstate == T4) && !parked;
  assign wait_req = access && (tstate == T2) && !bus.nwait;
  assign at_lim   = (wcnt == WMAX);
  assign stall    = wait_req && !at_lim;

  seq_tcnt u_tcnt (
    .clk    (clk),
    .nres   (nres),
    .stall  (stall),
    .park   (parked),
    .tstate (tstate)
  );

  // Request acceptance and park control, both decided on the T4 exit edge.
  // A simultaneous req wins over hold; hold is then re-sampled next T4.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      access <= 1'b0;
      we_r   <= 1'b0;
      dout_r <= '0;
      parked <= 1'b0;
    end else if (parked) begin
      parked <= bus.hold;
    end else if (leave_t4) begin
      access <= bus.req;
      parked <= bus.hold && !bus.req;
      if (bus.req) begin
        we_r   <= bus.we;
        dout_r <= bus.wdata;
      end
    end
  end

  // Wait counter: counts stretched T2 clocks, cleared at the start of each M-cycle.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres)              wcnt <= '0;
    else if (tstate == T1)  wcnt <= '0;
    else if (stall)         wcnt <= wcnt + WCNT_W'(1);
  end

  // Sticky timeout: set when the stretch limit forces T2 to end.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres)                 timeout_r <= 1'b0;
    else if (wait_req && at_lim) timeout_r <= 1'b1;
  end

  // Read data capture on the edge leaving T3, so it is valid alongside ack.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres)                                   rdata_r <= '0;
    else if (access && !we_r && tstate == T3)    rdata_r <= bus.din;
  end

  // Strobe decode from registered state; everything idles by default.
  always_comb begin
    bus.nmreq   = 1'b1;
    bus.nrd     = 1'b1;
    bus.nwr     = 1'b1;
    bus.addr_le = 1'b0;
    bus.dout_oe = 1'b0;
    bus.ack     = 1'b0;
    if (access && !parked) begin
      bus.addr_le = (tstate == T1);
      bus.ack     = (tstate == T4);
      if (we_r) begin
        // write: data driven the whole M-cycle, strobe only once it settled
        bus.dout_oe = 1'b1;
        if (tstate == T2 || tstate == T3) begin
          bus.nmreq = 1'b0;
          bus.nwr   = 1'b0;
        end
      end else if (tstate != T4) begin
        bus.nmreq = 1'b0;
        bus.nrd   = 1'b0;
      end
    end
  end

  assign bus.tstate  = tstate;
  assign bus.m_end   = (tstate == T4) && !parked;
  assign bus.parked  = parked;
  assign bus.timeout = timeout_r;
  assign bus.dout    = dout_r;
  assign bus.rdata   = rdata_r;

endmodule

// File: tb/tb_seq_bus_ctl.sv
// Directed bench for seq_bus_ctl: stimulus pushes expected access results
// into a queue, a negedge monitor pops and compares on every ack.
module tb_seq_bus_ctl;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic nres;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  acc_t sb[$];

  seq_bus_ctl_if bus();

  seq_bus_ctl #(.WAIT_MAX(15), .WCNT_W(4)) dut (
    .clk  (clk),
    .nres (nres),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {addr_le, nmreq, nrd, nwr, dout_oe}
  function automatic logic [4:0] strb();
    return {bus.addr_le, bus.nmreq, bus.nrd, bus.nwr, bus.dout_oe};
  endfunction

  task automatic go_t4();
    int n = 0;
    while (bus.tstate != 2'd3 && n < 40) begin tick(); n++; end
    chk("reach_t4", {30'd0, bus.tstate}, 32'd3);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (nres && bus.ack) begin
      if (sb.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
      else begin
        acc_t e;
        e = sb.pop_front();
        if (e.we) chk("sb_wr_dout", {24'd0, bus.dout}, {24'd0, e.data});
        else      chk("sb_rd_rdata", {24'd0, bus.rdata}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nres = 1'b0;
    bus.req = 0; bus.we = 0; bus.wdata = 0; bus.hold = 0;
    bus.nwait = 1; bus.din = 0;
    #2;
    chk("rst_tstate", {30'd0, bus.tstate}, 32'd0);
    chk("rst_strb", {27'd0, strb()}, {27'd0, 5'b01110});
    chk("rst_flags", {28'd0, bus.ack, bus.m_end, bus.timeout, bus.parked}, 32'd0);
    chk("rst_data", {16'd0, bus.dout, bus.rdata}, 32'd0);
    #10 nres = 1'b1;   // t=12, between edges

    // idle M-cycles
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk("idle_tstate", {30'd0, bus.tstate}, i % 4);
      chk("idle_flags", {27'd0, bus.m_end, bus.nmreq, bus.nrd, bus.nwr, bus.ack},
          {27'd0, (i % 4 == 3), 4'b1110});
    end

    // read A5
    bus.req = 1; bus.we = 0;
    sb.push_back('{we: 1'b0, data: 8'hA5});
    tick(); bus.req = 0;
    chk("rd_t1", {27'd0, strb()}, {27'd0, 5'b10010});
    tick(); chk("rd_t2", {27'd0, strb()}, {27'd0, 5'b00010});
    tick(); bus.din = 8'hA5; chk("rd_t3", {27'd0, strb()}, {27'd0, 5'b00010});
    tick(); chk("rd_t4", {26'd0, strb(), bus.ack}, {26'd0, 5'b01110, 1'b1});

    // write 3C, issued in the same T4
    bus.req = 1; bus.we = 1; bus.wdata = 8'h3C;
    sb.push_back('{we: 1'b1, data: 8'h3C});
    tick(); bus.req = 0; bus.we = 0; bus.wdata = 0;
    chk("wr_t1", {27'd0, strb()}, {27'd0, 5'b11111});
    chk("wr_dout", {24'd0, bus.dout}, 32'h3C);
    tick(); chk("wr_t2", {27'd0, strb()}, {27'd0, 5'b00101});
    tick(); chk("wr_t3", {27'd0, strb()}, {27'd0, 5'b00101});
    tick(); chk("wr_t4", {26'd0, strb(), bus.ack}, {26'd0, 5'b01111, 1'b1});
    tick(); chk("idle_after_wr", {27'd0, strb()}, {27'd0, 5'b01110});

    // short stretch: 3 wait clocks
    go_t4();
    bus.req = 1; bus.we = 0;
    sb.push_back('{we: 1'b0, data: 8'h5A});
    tick(); bus.req = 0; n = 1;
    tick(); bus.nwait = 0; n++;
    for (int i = 0; i < 3; i++) begin
      tick(); n++;
      chk("st_hold_t2", {30'd0, bus.tstate}, 32'd1);
    end
    bus.nwait = 1; bus.din = 8'h5A;
    tick(); n++; chk("st_t3", {30'd0, bus.tstate}, 32'd2);
    tick(); n++;
    chk("st_span", n, 32'd7);
    chk("st_ack_to", {30'd0, bus.ack, bus.timeout}, 32'b10);

    // limit stretch: nwait held low
    bus.req = 1; bus.we = 0;
    sb.push_back('{we: 1'b0, data: 8'hC3});
    tick(); bus.req = 0;
    tick(); bus.nwait = 0; bus.din = 8'hC3; n = 1;
    while (bus.tstate == 2'd1 && n < 40) begin
      tick();
      if (bus.tstate == 2'd1) n++;
    end
    chk("to_t2_clks", n, 32'd16);
    chk("to_t3_flag", {29'd0, bus.tstate, bus.timeout}, {29'd0, 2'd2, 1'b1});
    bus.nwait = 1;
    tick(); chk("to_t4_ack", {31'd0, bus.ack}, 32'd1);

    // hold / park, req ignored while parked
    bus.hold = 1;
    tick();
    chk("pk_enter", {27'd0, bus.parked, bus.tstate, bus.m_end, bus.addr_le}, {27'd0, 5'b10000});
    chk("pk_strb", {27'd0, strb()}, {27'd0, 5'b01110});
    bus.req = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("pk_stay", {27'd0, bus.parked, bus.tstate, bus.m_end, bus.addr_le}, {27'd0, 5'b10000});
    end
    bus.hold = 0;
    tick();
    chk("unpk", {26'd0, bus.parked, bus.tstate, bus.m_end, strb()}, {26'd0, 4'b0000, 5'b01110});
    bus.req = 0;
    tick(); chk("unpk_t2", {29'd0, bus.tstate, bus.nmreq}, {29'd0, 2'd1, 1'b1});
    tick(); tick();
    chk("unpk_t4", {28'd0, bus.tstate, bus.m_end, bus.ack}, {28'd0, 2'd3, 2'b10});
    bus.req = 1; bus.we = 1; bus.wdata = 8'h96;
    sb.push_back('{we: 1'b1, data: 8'h96});
    tick(); bus.req = 0; bus.we = 0;
    chk("unpk_acc", {27'd0, strb()}, {27'd0, 5'b11111});
    tick(); tick(); tick();
    chk("unpk_ack", {31'd0, bus.ack}, 32'd1);

    // req and hold together: access first, then park
    bus.req = 1; bus.we = 0; bus.hold = 1;
    sb.push_back('{we: 1'b0, data: 8'h11});
    tick(); bus.req = 0;
    chk("rh_t1", {30'd0, bus.parked, bus.addr_le}, 32'b01);
    tick(); tick(); bus.din = 8'h11;
    tick(); chk("rh_t4", {30'd0, bus.parked, bus.ack}, 32'b01);
    tick(); chk("rh_park", {29'd0, bus.parked, bus.tstate}, {29'd0, 3'b100});
    bus.hold = 0;
    tick(); chk("rh_unpk", {31'd0, bus.parked}, 32'd0);

    // async reset in T2 of a write
    go_t4();
    bus.req = 1; bus.we = 1; bus.wdata = 8'h77;
    tick(); bus.req = 0; bus.we = 0;
    tick(); chk("ar_pre", {29'd0, bus.nwr, bus.nmreq, bus.dout_oe}, 32'b001);
    #2 nres = 1'b0;
    #1;
    chk("ar_strb", {29'd0, bus.nwr, bus.nmreq, bus.dout_oe}, 32'b110);
    chk("ar_state", {22'd0, bus.tstate, bus.dout}, 32'd0);
    chk("ar_to_clr", {31'd0, bus.timeout}, 32'd0);
    tick(); tick();
    #3 nres = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seq_bus_ctl.md
Name: seq_bus_ctl

Overview:
- Bus-cycle sequencer for the CPU external memory interface.
- Frames every M-cycle into four T-states (T1..T4) and accepts one read or write request per M-cycle from the instruction sequencer.
- Drives the active-low nMREQ/nRD/nWR strobes, the address latch enable and the data output enable, and captures read data.
- Stretches T2 for slow memory (nwait) and parks the machine on a hold request (HALT/STOP).

Parameters:
- WAIT_MAX, 15, maximum number of consecutive stretched T2 clocks before the access is forced to complete.
- WCNT_W, 4, width of the wait counter; must satisfy 2^WCNT_W > WAIT_MAX.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- nres  in  1  asynchronous, active-low reset.
- req  in  1  access request for the next M-cycle, sampled in T4.
- we  in  1  1 = write, 0 = read; sampled with req.
- wdata  in  8  write data; sampled with req.
- hold  in  1  park request (HALT/STOP), sampled in T4.
- nwait  in  1  memory not-ready, active low; sampled only in T2 of an access.
- din  in  8  external data bus input.
- nmreq  out  1  memory request strobe, active low.
- nrd  out  1  read strobe, active low.
- nwr  out  1  write strobe, active low.
- addr_le  out  1  address latch enable.
- dout_oe  out  1  data output drive enable.
- dout  out  8  registered write data.
- rdata  out  8  captured read data.
- ack  out  1  one-clock pulse at T4 of a completed access.
- tstate  out  2  current T-state: 0=T1, 1=T2, 2=T3, 3=T4.
- m_end  out  1  high during T4 of every non-parked M-cycle.
- parked  out  1  machine frozen by hold.
- timeout  out  1  sticky flag: the WAIT_MAX limit was hit; cleared only by reset.

Behaviour:
- Reset (async, nres=0): tstate=T1, no access active, not parked.
  - Output values: nmreq=nrd=nwr=1, addr_le=0, dout_oe=0, ack=0, m_end=0, timeout=0, dout=0, rdata=0, wait count=0.
  - Asserting reset mid-access drops all strobes immediately. No ack is issued.
- T-counter: advances T1→T2→T3→T4→T1 each clk, except while stretching (held in T2) or parked.
- Request acceptance: on the clk edge that leaves T4, req=1 latches we and wdata (into dout) and marks the following M-cycle as an access. req=0 gives an idle M-cycle.
- Read access:
  - addr_le=1 in T1.
  - nmreq=0 and nrd=0 during T1, T2 (including stretch) and T3.
  - rdata is captured from din on the edge leaving T3.
  - ack=1 in T4, with rdata already valid.
- Write access:
  - addr_le=1 in T1.
  - dout_oe=1 during T1..T4.
  - nmreq=0 and nwr=0 during T2 (including stretch) and T3.
  - ack=1 in T4.
- Idle M-cycle: all strobes inactive, ack=0, m_end still pulses in T4.
- Wait stretch:
  - In T2 of an access, nwait=0 holds the machine in T2 and increments the wait count.
  - nwait=1 lets T2→T3.
  - If the wait count equals WAIT_MAX while nwait=0, the machine advances to T3 anyway and sets timeout=1.
  - The wait count clears at T1.
  - nwait is ignored in idle M-cycles and in all other T-states.
- Hold:
  - On the edge leaving T4, hold=1 with req=0 enters parked: tstate=T1, all strobes inactive, m_end=0, addr_le=0.
  - hold is sampled every clk while parked. On the edge where hold=0 is seen, parked clears and the machine runs a normal T1 on the next clk. The first M-cycle after unpark is idle.
  - req is ignored while parked.
- Simultaneous events:
  - req=1 and hold=1 in T4: the access is taken; hold is deferred to the next T4.
  - nwait=0 together with hitting the limit: the forced advance wins.
- Strobes are decoded only from registered state (tstate, access, we, parked). There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (seq_pkg): T-state encoding constants T1..T4, and the default WAIT_MAX.
- One natural sub-module: seq_tcnt, the 2-bit T-state counter with stall, park and async reset, reusable by the interrupt sequencer.
- Strobe decode and the data registers stay in seq_bus_ctl.

Test Plan:
- Reset then idle (req=0 for 3 M-cycles) -> tstate cycles 0,1,2,3 repeatedly; m_end high every 4th clk; nmreq=nrd=nwr=1 throughout; ack never 1.
- Read, req=1/we=0 in T4, din=8'hA5 in T3, nwait=1 -> next M-cycle addr_le=1 in T1; nmreq=nrd=0 in T1..T3; ack=1 in T4 with rdata=8'hA5; nwr stays 1.
- Write, req=1/we=1/wdata=8'h3C -> dout=8'h3C and dout_oe=1 in T1..T4; nwr=nmreq=0 in T2..T3 only; ack in T4.
- Wait stretch, read with nwait=0 for 3 clks in T2 -> T2 lasts 4 clks; access spans 7 clks; timeout=0. Repeat with nwait held low -> advance after WAIT_MAX=15 stretch clks; timeout=1 and stays 1.
- Hold, hold=1 and req=0 in T4 -> parked=1, tstate=0, m_end=0 for 10 clks. Drop hold -> parked=0 on the next edge, one idle M-cycle, then a req is accepted normally. Also drive req=1 and hold=1 together -> access completes, then park.
- Async reset: pulse nres=0 during T2 of a write -> nwr, nmreq and dout_oe deassert immediately without waiting for clk; tstate=0; no ack after release.
